sum_collect_stage: RTL and testbench

SUM_COLLECT_STAGE -- requirements
Module: sum_collect_stage

---
 rtl/sum_collect_stage.sv | 95 +++++++++
 tb/tb_sum_collect_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_collect_stage.sv
// Collects results from a fixed-latency pipelined adder into a small FIFO and
// keeps a running 16-bit sum of everything the consumer pops.
module sum_collect_stage #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               sum_in,
  input  logic                     cout_in,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8:0]               out_data,
  output logic [15:0]              acc,
  output logic                     acc_ovf,
  output logic                     drop_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [LATENCY-1:0] valid_pipe;
  logic               res_valid;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [8:0]         mem [DEPTH];
  logic [16:0]        acc_sum;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) valid_pipe[i] <= valid_pipe[i-1];
    end
  end

  assign res_valid = valid_pipe[LATENCY-1];
  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push      = res_valid && (!full || pop);
  assign drop      = res_valid && full && !pop;
  assign out_data  = mem[rd_ptr];
  assign acc_sum   = {1'b0, acc} + {8'd0, out_data};

  // NOTE: storage is not reset; out_data is only meaningful while out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cout_in, sum_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear wins over a same-cycle pop or drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      acc_ovf  <= 1'b0;
      drop_err <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      acc_ovf  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (pop) begin
        acc <= acc_sum[15:0];
        if (acc_sum[16]) acc_ovf <= 1'b1;
      end
      if (drop) drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sum_collect_stage.sv
// Bench for sum_collect_stage: directed scenarios plus random traffic, all
// compared each cycle against a queue-based model of the adder and FIFO.
module tb_sum_collect_stage;

  localparam int L    = 3;
  localparam int D    = 4;
  localparam int HMAX = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  sum_in;
  logic        cout_in;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_data;
  logic [15:0] acc;
  logic        acc_ovf;
  logic        drop_err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          iv_hist [HMAX];
  logic [8:0]  res_hist[HMAX];
  logic [8:0]  q[$];
  logic [15:0] m_acc;
  bit          m_ovf;
  bit          m_drop;
  logic [8:0]  fill_v[5];

  sum_collect_stage #(.LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sum_in(sum_in),
    .cout_in(cout_in), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .acc(acc),
    .acc_ovf(acc_ovf), .drop_err(drop_err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; the adder result for an issue made L cycles
  // earlier shows up on sum_in/cout_in now, otherwise the bus carries junk.
  task automatic drive(input bit iv, input logic [8:0] val, input bit rdy, input bit clr);
    in_valid      = iv;
    iv_hist[cyc]  = iv;
    res_hist[cyc] = val;
    out_ready     = rdy;
    clear         = clr;
    if (cyc >= L && iv_hist[cyc-L]) {cout_in, sum_in} = res_hist[cyc-L];
    else                            {cout_in, sum_in} = 9'($urandom);
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, q.size() != 0);
    check("count", count, q.size());
    if (q.size() != 0) check("out_data", out_data, q[0]);
    check("acc", acc, m_acc);
    check("acc_ovf", acc_ovf, m_ovf);
    check("drop_err", drop_err, m_drop);
  endtask

  // Advance the model by one clock edge, then compare after the edge.
  task automatic tick();
    bit          rv;
    logic [16:0] s;
    rv = (cyc >= L) && iv_hist[cyc-L];
    if (q.size() != 0 && out_ready) begin
      s = {1'b0, m_acc} + 17'(q[0]);
      void'(q.pop_front());
      if (!clear) begin
        m_acc = s[15:0];
        if (s[16]) m_ovf = 1'b1;
      end
    end
    if (clear) begin
      m_acc  = '0;
      m_ovf  = 1'b0;
      m_drop = 1'b0;
    end
    if (rv) begin
      if (q.size() < D) q.push_back(res_hist[cyc-L]);
      else if (!clear)  m_drop = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) begin
      drive(1'b0, 9'h0, rdy, 1'b0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; sum_in = '0; cout_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
    m_acc = '0; m_ovf = 1'b0; m_drop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_count", count, 0);
    check("reset_acc", acc, 0);
    check("reset_acc_ovf", acc_ovf, 0);
    check("reset_drop_err", drop_err, 0);
    reset = 1'b0;

    // Single result: 9'h1FF visible after the fourth edge, accumulated on the fifth.
    drive(1'b1, 9'h1FF, 1'b1, 1'b0);
    tick();
    idle(2, 1'b1);
    check("single_not_yet", out_valid, 0);
    idle(1, 1'b1);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 9'h1FF);
    idle(1, 1'b1);
    check("single_acc", acc, 16'h01FF);

    // Fill with five results and no consumer: the fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      fill_v[i] = 9'($urandom);
      drive(1'b1, fill_v[i], 1'b0, 1'b0);
      tick();
    end
    idle(L + 1, 1'b0);
    check("fill_count", count, 4);
    check("fill_drop_err", drop_err, 1);
    for (int i = 0; i < 4; i++) begin
      check("fill_drain_data", out_data, fill_v[i]);
      drive(1'b0, 9'h0, 1'b1, 1'b0);
      tick();
    end
    check("fill_empty", out_valid, 0);

    // Full FIFO with push and pop on the same edge.
    drive(1'b0, 9'h0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 9'($urandom), 1'b0, 1'b0);
      tick();
    end
    idle(L + 1, 1'b0);
    check("full_count", count, 4);
    drive(1'b1, 9'h0A5, 1'b0, 1'b0);
    tick();
    idle(L - 1, 1'b0);
    idle(1, 1'b1);
    check("simul_count", count, 4);
    check("simul_drop_err", drop_err, 0);
    idle(D + 2, 1'b1);

    // Overflow: accumulate to 16'hFF00, then pop 9'h100.
    drive(1'b0, 9'h0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 129; i++) begin
      drive(1'b1, (i < 127) ? 9'h1FF : ((i == 127) ? 9'h17F : 9'h100), 1'b1, 1'b0);
      tick();
    end
    idle(L + 2, 1'b1);
    check("ovf_acc", acc, 16'h0000);
    check("ovf_flag", acc_ovf, 1);
    drive(1'b0, 9'h0, 1'b0, 1'b1);
    tick();
    check("clear_acc", acc, 0);
    check("clear_ovf", acc_ovf, 0);

    // Reset mid-stream: three buffered, two in the adder pipeline.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 9'($urandom), 1'b0, 1'b0);
      tick();
    end
    idle(L + 1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 9'($urandom), 1'b0, 1'b0);
      tick();
    end
    check("pre_reset_count", count, 3);
    reset = 1'b1;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_acc", acc, 0);
    q.delete();
    m_acc = '0; m_ovf = 1'b0; m_drop = 1'b0;
    for (int i = 0; i <= cyc; i++) iv_hist[i] = 1'b0;
    reset = 1'b0;
    idle(L + 3, 1'b1);
    check("post_reset_idle", out_valid, 0);

    // Random traffic: low consumer rate first to exercise drops, then higher.
    for (int i = 0; i < 1024; i++) begin
      drive(1'($urandom), 9'($urandom),
            ($urandom % 100) < ((i < 512) ? 40 : 80),
            ($urandom % 64) == 0);
      tick();
    end
    idle(D + L + 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
